// File: rtl/embed_pkg.sv
// Shared types and constants for the patch-embedding sequencer.
// Token matrices are packed so they can be moved as a single bus.
package embed_pkg;

    localparam int N_SAMP  = 15;
    localparam int N_TOK   = 16;
    localparam int D_MODEL = 16;
    localparam int DW      = 8;
    localparam int TIMEOUT = 511;
    localparam int TMR_W   = 9;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT,
        STREAM
    } state_t;

    typedef logic signed [DW-1:0]       q44_t;
    typedef q44_t    [D_MODEL-1:0]      tok_row_t;
    typedef tok_row_t [N_TOK-1:0]       tok_mat_t;

endpackage

// File: rtl/embed_tok_buffer.sv
// Capture register for one 16x16 token matrix, loaded in a single cycle
// and read back one row at a time.
module embed_tok_buffer
    import embed_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [N_TOK*D_MODEL*DW-1:0]   din,
    input  logic [CNT_W-1:0]              rd_idx,
    output logic [D_MODEL*DW-1:0]         rd_row
);

    tok_mat_t mem;

    // NOTE: this storage is reset on purpose; tok_data must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (load) begin
            mem <= tok_mat_t'(din);
        end
    end

    assign rd_row = mem[rd_idx];

endmodule

// File: rtl/embed_seq_ctrl.sv
// Sequencer for the patch-embedding datapath: serial sample collection,
// guarded datapath launch, and row-by-row token streaming.
module embed_seq_ctrl
    import embed_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW-1:0]                 in_sample,
    output logic [N_SAMP*DW-1:0]          dp_ecg,
    output logic                          dp_start,
    input  logic                          dp_done,
    input  logic [N_TOK*D_MODEL*DW-1:0]   dp_result,
    output logic                          tok_valid,
    input  logic                          tok_ready,
    output logic [D_MODEL*DW-1:0]         tok_data,
    output logic [3:0]                    tok_idx,
    output logic                          tok_last,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam logic [CNT_W-1:0] SCNT_LAST = CNT_W'(N_SAMP - 1);
    localparam logic [CNT_W-1:0] RCNT_LAST = CNT_W'(N_TOK - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    scnt_q;
    logic [CNT_W-1:0]    rcnt_q;
    logic [TMR_W-1:0]    timer_q;
    logic                err_q;
    q44_t [N_SAMP-1:0]   samp_buf;

    logic in_hs;
    logic tok_hs;
    logic capture;
    logic timed_out;

    assign in_hs     = in_ready & in_valid;
    assign tok_hs    = tok_valid & tok_ready;
    assign timed_out = (state_q == WAIT) && !dp_done && (timer_q == TMR_LIMIT);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        dp_start  = 1'b0;
        tok_valid = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && scnt_q == SCNT_LAST) state_d = RUN;
            end
            RUN: begin
                dp_start = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // A completion in the timeout cycle still counts as success.
                if (dp_done) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end else if (timer_q == TMR_LIMIT) begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                tok_valid = 1'b1;
                if (tok_ready && rcnt_q == RCNT_LAST) state_d = en ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            scnt_q   <= '0;
            rcnt_q   <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            samp_buf <= '0;
        end else begin
            state_q <= state_d;

            if (in_hs) begin
                samp_buf[scnt_q] <= q44_t'(in_sample);
                scnt_q           <= (scnt_q == SCNT_LAST) ? '0 : scnt_q + 1'b1;
                err_q            <= 1'b0;
            end else if (timed_out) begin
                err_q <= 1'b1;
            end

            if (state_q == RUN) begin
                timer_q <= '0;
            end else if (state_q == WAIT) begin
                timer_q <= timer_q + 1'b1;
            end

            // rcnt rolls 15->0 on the final accepted row, which is also when STREAM ends.
            if (capture) begin
                rcnt_q <= '0;
            end else if (tok_hs) begin
                rcnt_q <= rcnt_q + 1'b1;
            end
        end
    end

    embed_tok_buffer u_tok_buffer (
        .clk    (clk),
        .rst    (rst),
        .load   (capture),
        .din    (dp_result),
        .rd_idx (rcnt_q),
        .rd_row (tok_data)
    );

    assign dp_ecg      = samp_buf;
    assign tok_idx     = rcnt_q;
    assign tok_last    = tok_valid && (rcnt_q == RCNT_LAST);
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_embed_seq_ctrl.sv
// Self-checking bench for embed_seq_ctrl with randomized windows and matrices.
// Expected timing and data come from the sequencer's protocol rules.
module tb_embed_seq_ctrl;
    import embed_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          en = 1'b0;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [DW-1:0]                 in_sample = '0;
    logic [N_SAMP*DW-1:0]          dp_ecg;
    logic                          dp_start;
    logic                          dp_done = 1'b0;
    logic [N_TOK*D_MODEL*DW-1:0]   dp_result = '0;
    logic                          tok_valid;
    logic                          tok_ready = 1'b0;
    logic [D_MODEL*DW-1:0]         tok_data;
    logic [3:0]                    tok_idx;
    logic                          tok_last;
    logic                          busy;
    logic                          err_timeout;

    int errors = 0;
    int checks = 0;

    logic [7:0] win [N_SAMP];
    logic [7:0] mat [N_TOK][D_MODEL];

    embed_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sample   (in_sample),
        .dp_ecg      (dp_ecg),
        .dp_start    (dp_start),
        .dp_done     (dp_done),
        .dp_result   (dp_result),
        .tok_valid   (tok_valid),
        .tok_ready   (tok_ready),
        .tok_data    (tok_data),
        .tok_idx     (tok_idx),
        .tok_last    (tok_last),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_SAMP*DW-1:0] pack_win();
        logic [N_SAMP*DW-1:0] v;
        for (int i = 0; i < N_SAMP; i++) v[i*DW +: DW] = win[i];
        return v;
    endfunction

    function automatic logic [D_MODEL*DW-1:0] pack_row(input int r);
        logic [D_MODEL*DW-1:0] v;
        for (int c = 0; c < D_MODEL; c++) v[c*DW +: DW] = mat[r][c];
        return v;
    endfunction

    function automatic logic [N_TOK*D_MODEL*DW-1:0] pack_mat();
        logic [N_TOK*D_MODEL*DW-1:0] v;
        for (int r = 0; r < N_TOK; r++) v[r*D_MODEL*DW +: D_MODEL*DW] = pack_row(r);
        return v;
    endfunction

    function automatic logic [N_TOK*D_MODEL*DW-1:0] rand_wide();
        logic [N_TOK*D_MODEL*DW-1:0] v;
        for (int i = 0; i < (N_TOK*D_MODEL*DW)/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic new_random_window();
        for (int i = 0; i < N_SAMP; i++) win[i] = 8'($urandom);
        for (int r = 0; r < N_TOK; r++)
            for (int c = 0; c < D_MODEL; c++) mat[r][c] = 8'($urandom);
    endtask

    // Feeds win[] while the DUT is in LOAD; ends in the cycle where dp_start is expected.
    task automatic load_window(input int gap_pct, input bit stray_done, output logic err_after_first);
        int  idx = 0;
        int  budget = 0;
        bit  hs;
        err_after_first = 1'bx;
        while (idx < N_SAMP && budget < 2000) begin
            in_valid  = ($urandom_range(99) >= gap_pct);
            in_sample = in_valid ? win[idx] : 8'($urandom);
            dp_done   = stray_done && ($urandom_range(3) == 0);
            dp_result = rand_wide();
            checks++;
            if (in_ready !== 1'b1 || tok_valid !== 1'b0 || dp_start !== 1'b0) begin
                errors++;
                $display("FAIL load_beat idx=%0d: in_ready=%b tok_valid=%b dp_start=%b, required 1 0 0",
                         idx, in_ready, tok_valid, dp_start);
            end
            hs = in_valid && in_ready;
            tick();
            budget++;
            if (hs) begin
                idx++;
                if (idx == 1) err_after_first = err_timeout;
            end
        end
        in_valid = 1'b0;
        dp_done  = 1'b0;
        checks++;
        if (idx < N_SAMP) begin
            errors++;
            $display("FAIL load_budget: accepted %0d beats, required %0d", idx, N_SAMP);
        end
        checks++;
        if (dp_start !== 1'b1 || in_ready !== 1'b0 || dp_ecg !== pack_win()) begin
            errors++;
            $display("FAIL launch: dp_start=%b in_ready=%b dp_ecg=%h, required 1 0 %h",
                     dp_start, in_ready, dp_ecg, pack_win());
        end
    endtask

    // Starts in the dp_start cycle; raises dp_done 'delay' cycles later (timer = delay-1).
    task automatic wait_done(input int delay);
        for (int k = 1; k <= delay; k++) begin
            in_valid  = 1'b1;
            in_sample = 8'($urandom);
            tick();
            checks++;
            if (in_ready !== 1'b0 || dp_start !== 1'b0 || tok_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL wait_cycle k=%0d: in_ready=%b dp_start=%b tok_valid=%b busy=%b, required 0 0 0 1",
                         k, in_ready, dp_start, tok_valid, busy);
            end
        end
        in_valid  = 1'b0;
        dp_done   = 1'b1;
        dp_result = pack_mat();
        checks++;
        if (dp_ecg !== pack_win()) begin
            errors++;
            $display("FAIL ecg_stable: dp_ecg=%h, required %h", dp_ecg, pack_win());
        end
        tick();
        dp_done   = 1'b0;
        dp_result = rand_wide();
    endtask

    // Starts in the first STREAM cycle; mode 0 ready=1, 1 pattern 1-0-0-1, 2 random.
    task automatic stream_rows(input int mode, input int stop_after);
        int row = 0;
        int cyc = 0;
        bit hs;
        while (row < stop_after && cyc < 400) begin
            case (mode)
                0:       tok_ready = 1'b1;
                1:       tok_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: tok_ready = 1'($urandom_range(1));
            endcase
            checks++;
            if (tok_valid !== 1'b1 || tok_idx !== 4'(row) || tok_data !== pack_row(row)
                || tok_last !== (row == N_TOK - 1)) begin
                errors++;
                $display("FAIL row %0d cyc %0d: valid=%b idx=%0d last=%b data=%h, required 1 %0d %b %h",
                         row, cyc, tok_valid, tok_idx, tok_last, tok_data, row,
                         (row == N_TOK - 1), pack_row(row));
            end
            hs = tok_ready;
            tick();
            cyc++;
            if (hs) row++;
        end
        tok_ready = 1'b0;
        checks++;
        if (row < stop_after) begin
            errors++;
            $display("FAIL stream_budget: accepted %0d rows, required %0d", row, stop_after);
        end
        if (stop_after == N_TOK) begin
            if (mode == 0) begin
                checks++;
                if (cyc != N_TOK) begin
                    errors++;
                    $display("FAIL stream_rate: took %0d cycles, required %0d", cyc, N_TOK);
                end
            end
            checks++;
            if (tok_valid !== 1'b0 || busy !== en || in_ready !== en) begin
                errors++;
                $display("FAIL stream_exit: tok_valid=%b busy=%b in_ready=%b, required 0 %b %b",
                         tok_valid, busy, in_ready, en, en);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, dp_start, tok_valid, tok_last, busy, err_timeout} !== 6'b0
            || dp_ecg !== '0 || tok_data !== '0 || tok_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b ecg=%h data=%h idx=%0d, required all zero",
                     {in_ready, dp_start, tok_valid, tok_last, busy, err_timeout}, dp_ecg, tok_data, tok_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || dp_ecg !== '0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b in_ready=%b ecg=%h, required 0 0 0", busy, in_ready, dp_ecg);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic e;
        for (int i = 0; i < N_SAMP; i++) win[i] = 8'((i + 1) * 16);
        for (int r = 0; r < N_TOK; r++)
            for (int c = 0; c < D_MODEL; c++) mat[r][c] = 8'(r * 16 + c);
        en = 1'b1;
        tick();
        load_window(0, 1'b0, e);
        checks++;
        if (dp_ecg[14*DW +: DW] !== 8'hF0) begin
            errors++;
            $display("FAIL basic_ecg14: got %h, required f0", dp_ecg[14*DW +: DW]);
        end
        wait_done(20);
        stream_rows(0, N_TOK);
    endtask

    task automatic test_backpressure();
        logic e;
        new_random_window();
        load_window(0, 1'b0, e);
        en = 1'b0;
        wait_done(int'($urandom_range(1, 40)));
        stream_rows(1, N_TOK);
    endtask

    task automatic test_timeout();
        logic e;
        bit   saw_valid = 0;
        new_random_window();
        en = 1'b1;
        tick();
        load_window(0, 1'b0, e);
        en = 1'b0;
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            tick();
            if (tok_valid) saw_valid = 1;
        end
        checks++;
        if (busy !== 1'b1 || err_timeout !== 1'b0 || saw_valid) begin
            errors++;
            $display("FAIL timeout_edge: busy=%b err=%b saw_valid=%b, required 1 0 0", busy, err_timeout, saw_valid);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || tok_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: err=%b busy=%b tok_valid=%b, required 1 0 0", err_timeout, busy, tok_valid);
        end
        new_random_window();
        en = 1'b1;
        tick();
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, required 1", err_timeout);
        end
        load_window(0, 1'b0, e);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err after first beat=%b, required 0", e);
        end
        en = 1'b0;
        wait_done(5);
        stream_rows(0, N_TOK);
    endtask

    task automatic test_race();
        logic e;
        new_random_window();
        en = 1'b1;
        tick();
        load_window(0, 1'b0, e);
        en = 1'b0;
        wait_done(TIMEOUT + 1);
        checks++;
        if (err_timeout !== 1'b0 || tok_valid !== 1'b1) begin
            errors++;
            $display("FAIL race: err=%b tok_valid=%b, required 0 1", err_timeout, tok_valid);
        end
        stream_rows(2, N_TOK);
    endtask

    task automatic test_stray_gaps();
        logic e;
        new_random_window();
        for (int k = 0; k < 5; k++) begin
            in_valid  = 1'b1;
            in_sample = 8'($urandom);
            dp_done   = 1'b1;
            dp_result = rand_wide();
            tick();
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0 || tok_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_stray k=%0d: in_ready=%b busy=%b tok_valid=%b, required 0 0 0",
                         k, in_ready, busy, tok_valid);
            end
        end
        in_valid = 1'b0;
        dp_done  = 1'b0;
        en = 1'b1;
        tick();
        load_window(30, 1'b1, e);
        wait_done(int'($urandom_range(1, 30)));
        stream_rows(2, N_TOK);
    endtask

    task automatic test_reset_mid();
        logic e;
        new_random_window();
        load_window(0, 1'b0, e);
        wait_done(20);
        stream_rows(0, 8);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, dp_start, tok_valid, tok_last, busy, err_timeout} !== 6'b0
            || dp_ecg !== '0 || tok_data !== '0 || tok_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: flags=%b ecg=%h data=%h idx=%0d, required all zero",
                     {in_ready, dp_start, tok_valid, tok_last, busy, err_timeout}, dp_ecg, tok_data, tok_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        new_random_window();
        load_window(0, 1'b0, e);
        wait_done(int'($urandom_range(1, 40)));
        stream_rows(0, N_TOK);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_race();
        test_stray_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/embed_seq_ctrl.md
Name: embed_seq_ctrl

Overview:
Sequencer for the patch-embedding datapath (ECG samples × embedding weights + bias, ReLU, class-token concat, positional add).
- Collects one ECG window serially from the sample front-end and presents it to the datapath as a stable parallel vector.
- Launches the datapath and guards its completion with a timeout.
- Captures the 16×16 token matrix and streams it row by row, with valid/ready, to the attention stage.

Parameters:
N_SAMP, 15, samples per ECG window
N_TOK, 16, tokens per result matrix (rows)
D_MODEL, 16, elements per token (columns)
DW, 8, element width, signed Q4.4
TIMEOUT, 511, max cycles in WAIT before abort (9-bit timer)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
en  in  1  enable; sampled only in IDLE and at end of STREAM
in_valid  in  1  sample beat valid
in_ready  out  1  sample beat accepted when in_valid&in_ready
in_sample  in  DW  signed Q4.4 ECG sample
dp_ecg  out  N_SAMP×DW  parallel sample vector to datapath; held stable from RUN through WAIT
dp_start  out  1  one-cycle launch pulse to datapath
dp_done  in  1  datapath completion pulse
dp_result  in  N_TOK×D_MODEL×DW  datapath token matrix; valid in dp_done cycle
tok_valid  out  1  token row valid
tok_ready  in  1  downstream accepts row when tok_valid&tok_ready
tok_data  out  D_MODEL×DW  current token row
tok_idx  out  4  row index 0..15
tok_last  out  1  high with row 15
busy  out  1  state != IDLE
err_timeout  out  1  sticky; set on WAIT timeout, cleared on next accepted sample beat

Behaviour:
Reset values: state IDLE; all outputs 0; sample buffer, token buffer, sample counter, row counter and timer cleared. Reset mid-operation aborts immediately and drops any partial window or partial stream.

FSM states: IDLE, LOAD, RUN, WAIT, STREAM.
- IDLE: en=1 → LOAD.
- LOAD:
  - in_ready=1.
  - Each handshake writes buf[scnt] and increments scnt.
  - Handshake with scnt==N_SAMP-1 → RUN, scnt←0.
- RUN:
  - dp_start=1 for exactly one cycle, then → WAIT, timer←0.
  - dp_start therefore rises the cycle after the 15th sample is accepted.
- WAIT:
  - Timer increments each cycle.
  - dp_done=1 → capture dp_result into the token buffer, → STREAM, rcnt←0.
  - Else timer==TIMEOUT → err_timeout←1, → IDLE.
  - dp_done and timer==TIMEOUT in the same cycle: done wins, no error.
- STREAM:
  - tok_valid=1; tok_data=tokbuf[rcnt]; tok_idx=rcnt; tok_last=(rcnt==N_TOK-1).
  - Each handshake increments rcnt.
  - Last handshake → LOAD if en=1, else IDLE.
  - First tok_valid appears the cycle after dp_done.

Handshake and stability rules:
- tok_valid, once high, stays high, and tok_data/tok_idx stay constant, until accepted.
- tok_ready is ignored while tok_valid=0.
- in_ready=0 outside LOAD; in_valid is ignored outside LOAD.
- dp_done is ignored outside WAIT; no capture occurs.
- dp_ecg is driven from the sample buffer and only changes on LOAD handshakes. The datapath must not be relied on outside RUN/WAIT.
- en deassertion during LOAD, RUN, WAIT or STREAM has no effect until the end of STREAM.

Arithmetic: no arithmetic on data; samples and tokens pass through bit-exact. Counters saturate-free:
- scnt 4 bits, range 0..14.
- rcnt 4 bits, wraps 15→0 only on leaving STREAM.
- Timer 9 bits.

Throughput: back-to-back windows, with LOAD for the next window starting the cycle after tok_last is accepted.

Decomposition:
- Package embed_pkg: state enum (IDLE, LOAD, RUN, WAIT, STREAM); constants N_SAMP, N_TOK, D_MODEL, DW, TIMEOUT; typedef q44_t (signed [7:0]); typedefs tok_row_t (q44_t [D_MODEL]) and tok_mat_t (tok_row_t [N_TOK]).
- One sub-module: embed_tok_buffer. It holds the 16×16 capture register with a load strobe and a row-read port indexed by rcnt. The FSM, counters and timer stay in the top.

Test Plan:
- Basic window: en=1; stream samples 0x10,0x20..0xF0 (15 beats, in_valid always high); datapath model returns dp_done 20 cycles after dp_start with row r, element c = r*16+c; tok_ready=1 → dp_start exactly one cycle after beat 15; dp_ecg[14]=0xF0; 16 rows in consecutive cycles; row 15 = 0xF0..0xFF with tok_last=1; returns to LOAD.
- Backpressure: same stimulus, tok_ready toggling 1-0-0-1 → each row held stable while ready low; no row skipped or duplicated; tok_idx sequence exactly 0..15.
- Timeout: datapath model never asserts dp_done → err_timeout=1 at WAIT cycle 511, state IDLE, no tok_valid. Next window: err_timeout clears on the first accepted beat.
- Race: dp_done asserted exactly at timer==511 → STREAM entered, err_timeout stays 0.
- Stray done and input gaps: dp_done pulsed during LOAD; in_valid with random gaps → no capture, in_ready low outside LOAD, sample order preserved in dp_ecg.
- Reset mid-stream: assert rst after row 7 accepted → all outputs 0 asynchronously. After release with en=1, a fresh window completes correctly from row 0.
